// File: rtl/hanning_remove.sv
// Inverse sine-window stage: divides each windowed sample by the 128-point
// Q1.14 window coefficient using a one-bit-per-clock restoring divider.
module hanning_remove #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6:0]            index,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out,
  output logic                  ready,
  output logic                  busy,
  output logic                  sat
);

  localparam int QW = data_width + 14;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);
  localparam logic [data_width-1:0] MAX_POS = {1'b0, {(data_width-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state;
  logic            sign;
  logic [14:0]     divisor;
  logic [14:0]     rem;
  logic [QW-1:0]   dq;      // dividend shifts out the top, quotient shifts in the bottom
  logic [CW-1:0]   count;

  logic [data_width-1:0] mag;
  logic [15:0]           trial;
  logic                  take;
  logic [14:0]           next_rem;
  logic                  overflow;
  logic [data_width-1:0] mag_res;

  // Coefficients for 0..64; the upper half of the window mirrors the lower.
  function automatic logic [14:0] coef(input logic [6:0] idx);
    logic [6:0] k;
    k = (idx > 7'd64) ? 7'd0 - idx : idx;
    case (k)
      7'd1:  coef = 15'd402;   7'd2:  coef = 15'd803;   7'd3:  coef = 15'd1205;  7'd4:  coef = 15'd1605;
      7'd5:  coef = 15'd2005;  7'd6:  coef = 15'd2404;  7'd7:  coef = 15'd2801;  7'd8:  coef = 15'd3196;
      7'd9:  coef = 15'd3589;  7'd10: coef = 15'd3980;  7'd11: coef = 15'd4369;  7'd12: coef = 15'd4756;
      7'd13: coef = 15'd5139;  7'd14: coef = 15'd5519;  7'd15: coef = 15'd5896;  7'd16: coef = 15'd6269;
      7'd17: coef = 15'd6639;  7'd18: coef = 15'd7005;  7'd19: coef = 15'd7366;  7'd20: coef = 15'd7723;
      7'd21: coef = 15'd8075;  7'd22: coef = 15'd8423;  7'd23: coef = 15'd8765;  7'd24: coef = 15'd9102;
      7'd25: coef = 15'd9434;  7'd26: coef = 15'd9759;  7'd27: coef = 15'd10079; 7'd28: coef = 15'd10393;
      7'd29: coef = 15'd10701; 7'd30: coef = 15'd11002; 7'd31: coef = 15'd11297; 7'd32: coef = 15'd11585;
      7'd33: coef = 15'd11866; 7'd34: coef = 15'd12139; 7'd35: coef = 15'd12406; 7'd36: coef = 15'd12665;
      7'd37: coef = 15'd12916; 7'd38: coef = 15'd13159; 7'd39: coef = 15'd13395; 7'd40: coef = 15'd13622;
      7'd41: coef = 15'd13842; 7'd42: coef = 15'd14053; 7'd43: coef = 15'd14255; 7'd44: coef = 15'd14449;
      7'd45: coef = 15'd14634; 7'd46: coef = 15'd14810; 7'd47: coef = 15'd14978; 7'd48: coef = 15'd15136;
      7'd49: coef = 15'd15286; 7'd50: coef = 15'd15426; 7'd51: coef = 15'd15557; 7'd52: coef = 15'd15678;
      7'd53: coef = 15'd15790; 7'd54: coef = 15'd15892; 7'd55: coef = 15'd15985; 7'd56: coef = 15'd16069;
      7'd57: coef = 15'd16142; 7'd58: coef = 15'd16206; 7'd59: coef = 15'd16260; 7'd60: coef = 15'd16305;
      7'd61: coef = 15'd16339; 7'd62: coef = 15'd16364; 7'd63: coef = 15'd16379; 7'd64: coef = 15'd16384;
      default: coef = 15'd0;
    endcase
  endfunction

  // NOTE: every always_comb output gets an unconditional assignment first so no path can infer a latch.
  always_comb begin
    mag      = data_in[data_width-1] ? (~data_in + 1'b1) : data_in;
    trial    = {rem, dq[QW-1]};
    take     = (trial >= {1'b0, divisor});
    next_rem = take ? 15'(trial - {1'b0, divisor}) : trial[14:0];
    overflow = |dq[QW-1:data_width-1];
    mag_res  = overflow ? MAX_POS : dq[data_width-1:0];
  end

  // NOTE: reset is synchronous here to match the surrounding frame path; it still clears every register.
  // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign     <= 1'b0;
      divisor  <= '0;
      rem      <= '0;
      dq       <= '0;
      count    <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            sign    <= data_in[data_width-1];
            divisor <= coef(index);
            dq      <= {mag, 14'b0};
            rem     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= DIV;
          end
        end
        DIV: begin
          rem   <= next_rem;
          dq    <= {dq[QW-2:0], take};
          count <= count + CW'(1);
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          ready <= 1'b1;
          if (divisor == 15'd0) begin
            data_out <= '0;
            sat      <= 1'b1;
          end else begin
            data_out <= sign ? (~mag_res + 1'b1) : mag_res;
            sat      <= overflow;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hanning_remove.sv
// Scoreboard bench for hanning_remove: stimulus pushes expected results,
// an independent monitor pops and compares on every ready pulse.
module tb_hanning_remove;

  localparam int LAT = 47;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  index;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        busy;
  logic        sat;

  hanning_remove #(.data_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .index(index), .data_in(data_in),
    .data_out(data_out), .ready(ready), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: real-valued sine window and 64-bit integer division.
  task automatic model(input logic [6:0] idx, input logic [31:0] d,
                       output logic [31:0] q, output logic s);
    int     w;
    longint sd, m, r;
    w  = int'($floor($sin(3.141592653589793 * idx / 128.0) * 16384.0));
    sd = longint'($signed(d));
    m  = (sd < 0) ? -sd : sd;
    if (w == 0) begin
      q = 32'd0;
      s = 1'b1;
    end else begin
      r = (m * 16384) / w;
      s = (r > 64'sh7FFF_FFFF);
      if (s) r = 64'sh7FFF_FFFF;
      q = 32'((sd < 0) ? -r : r);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ready) begin
      check("ready_one_cycle", prev_ready, 0);
      if (sb.size() == 0) begin
        check("unexpected_ready", ready, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", data_out, e.data);
        check("sat", sat, e.sat);
        check("latency", edge_cnt - e.edge_no, LAT);
      end
    end
    prev_ready = rst_n && ready;
  end

  // NOTE: bench inputs are driven with blocking assignments 1 time unit after the edge.
  task automatic issue(input logic [6:0] idx, input logic [31:0] d,
                       input logic [31:0] q, input logic s);
    exp_t e;
    start   = 1'b1;
    index   = idx;
    data_in = d;
    e.data = q; e.sat = s; e.edge_no = edge_cnt + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic vec(input logic [6:0] idx, input logic [31:0] d,
                     input logic [31:0] q, input logic s);
    issue(idx, d, q, s);
    drain();
  endtask

  task automatic vec_busy(input logic [6:0] idx, input logic [31:0] d, input logic [31:0] q);
    int busy_cnt = 0;
    issue(idx, d, q, 1'b0);
    repeat (60) begin
      @(negedge clk);
      busy_cnt += int'(busy);
    end
    check("busy_cycles", busy_cnt, LAT);
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic        s;
    int          next_free;

    // Start held during reset must be dropped.
    rst_n = 1'b0; start = 1'b1; index = 7'd64; data_in = 32'd1000;
    repeat (3) @(posedge clk);
    #1; start = 1'b0; rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_state", {data_out, ready, busy, sat}, 0);
    end
    @(posedge clk); #1;

    vec_busy(7'd64, 32'd1000, 32'd1000);
    vec_busy(7'd64, -32'sd1000, -32'sd1000);
    vec(7'd32, 32'd11585, 32'd16384, 1'b0);
    vec(7'd1, 32'd402, 32'd16384, 1'b0);
    vec(7'd127, 32'h0010_0000, 32'd42735992, 1'b0);
    vec(7'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    vec(7'd1, 32'h8000_0000, 32'h8000_0001, 1'b1);
    vec(7'd0, 32'd5, 32'd0, 1'b1);
    vec(7'd64, 32'd0, 32'd0, 1'b0);
    vec(7'd0, 32'd0, 32'd0, 1'b1);
    vec(7'd96, -32'sd11585, -32'sd16384, 1'b0);
    vec(7'd65, 32'd16379, 32'd16384, 1'b0);
    vec(7'd127, -32'sd402, -32'sd16384, 1'b0);

    // Coefficient sweep over every window position.
    for (int i = 0; i < 128; i++) begin
      logic [31:0] d;
      d = (i % 2 == 1) ? -(32'h0001_0000 + 32'(i)) : (32'h0001_0000 + 32'(i));
      model(7'(i), d, q, s);
      vec(7'(i), d, q, s);
    end

    // Start every cycle: only starts seen while idle are taken.
    next_free = 0;
    for (int c = 0; c < 100; c++) begin
      exp_t e;
      start   = 1'b1;
      index   = 7'(c * 37 + 5);
      data_in = 32'(c) * 32'h0135_79BD ^ 32'hA5A5_0000;
      if (edge_cnt + 1 >= next_free) begin
        model(index, data_in, q, s);
        e.data = q; e.sat = s; e.edge_no = edge_cnt + 1;
        sb.push_back(e);
        next_free = edge_cnt + 1 + LAT + 1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    drain();

    // Reset in the middle of a division aborts it.
    issue(7'd32, 32'd11585, 32'd16384, 1'b0);
    repeat (19) @(posedge clk);
    #1; rst_n = 1'b0; sb.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("abort_state", {data_out, ready, busy, sat}, 0);
    repeat (60) @(posedge clk);
    #1;
    check("abort_quiet", {data_out, busy, sat}, 0);
    vec(7'd16, 32'd6269, 32'd16384, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
